// File: rtl/rv32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv32_pkg : RV32I format codes, opcode constants, encoder FSM states        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package rv32_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // True when value is a sign-extension of its bits [msb:0].
    function automatic logic fits_signed(input logic [31:0] value, input int msb);
        logic signed [31:0] shifted;
        shifted = $signed(value) >>> msb;
        return (shifted == '0) || (shifted == '1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_pack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_pack : combinational RV32I field packer with immediate legality flag   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module imm_pack
    import rv32_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        legal
);

    always_comb begin
        instr = 32'd0;
        legal = 1'b0;
        case (fmt)
            FMT_R: begin
                instr = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
            FMT_I: begin
                instr = {imm[11:0], rs1, funct3, rd, opcode};
                legal = fits_signed(imm, 11);
            end
            FMT_S: begin
                instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = fits_signed(imm, 11);
            end
            FMT_B: begin
                instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal = fits_signed(imm, 12) && !imm[0];
            end
            FMT_U: begin
                instr = {imm[31:12], rd, opcode};
                legal = (imm[11:0] == 12'd0);
            end
            FMT_J: begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal = fits_signed(imm, 20) && !imm[0];
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_encoder : RV32I encoder streaming packed words to an imem write port |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module instr_encoder
    import rv32_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done,
    output logic              err,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_step      = ADDR_W'(4);

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_accept;

    imm_pack u_imm_pack (
        .fmt    (in_fmt),
        .opcode (in_opcode),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .imm    (in_imm),
        .instr  (w_word),
        .legal  (w_legal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                in_ready = !out_valid || out_ready;
                if (in_valid && (!out_valid || out_ready) && in_last) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!out_valid || out_ready) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_accept = in_valid && in_ready;

    // Illegal bundles are consumed but leave the output register and address untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_instr  <= 32'd0;
            out_addr   <= c_base_addr;
            r_addr_cnt <= c_base_addr;
            err        <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_addr_cnt <= c_base_addr;
                err        <= 1'b0;
                err_count  <= 8'd0;
            end
            if (w_accept && w_legal) begin
                out_valid  <= 1'b1;
                out_instr  <= w_word;
                out_addr   <= r_addr_cnt;
                r_addr_cnt <= r_addr_cnt + c_step;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (w_accept && !w_legal) begin
                err <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire
